// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush and operand-forwarding control for the 5-stage core.
//
// Keeps a shadow copy of the Memory- and Writeback-stage destination info,
// so only Execute- and Decode-side inputs are needed.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the LdStallCnt/FlushCnt
// performance counters. Without it neither port nor counter logic exists.
//
// Ports:
//   CLK, RST_N           clock, synchronous active-low reset
//   RA1D, RA2D           Decode source registers
//   RA1E, RA2E, WA3E     Execute source/destination registers
//   RegWriteE, MemtoRegE Execute writes a register / is a load
//   PCSrcD, PCSrcE       Decode / Execute instruction writes the PC
//   BranchTakenE         conditional branch resolved taken in Execute
//   StallF, StallD       hold fetch PC / Fetch-Decode register
//   FlushD, FlushE       clear Fetch-Decode / Decode-Execute register
//   ForwardAE, ForwardBE operand select: 00 regfile, 01 WB result, 10 MEM ALU result
//   LdStallCnt, FlushCnt (HAZARD_PERF_CNT_EN only) event counters
module hazard_unit #(
    parameter int unsigned RBITS = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [RBITS-1:0] RA1D,
    input  logic [RBITS-1:0] RA2D,
    input  logic [RBITS-1:0] RA1E,
    input  logic [RBITS-1:0] RA2E,
    input  logic [RBITS-1:0] WA3E,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]      LdStallCnt,
    output logic [31:0]      FlushCnt
`endif
);

    localparam logic [RBITS-1:0] PC_REG = RBITS'(15);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Shadow Memory/Writeback stage info
    logic [RBITS-1:0] wa3_m;
    logic             reg_write_m;
    logic             mem_to_reg_m;
    logic             pc_src_m;
    logic [RBITS-1:0] wa3_w;
    logic             reg_write_w;
    logic             pc_src_w;

    logic ldr_stall;
    logic pc_wr_pend;

    // Shadow pipeline advances every cycle; E onward never stalls.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wa3_m        <= '0;
            reg_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            pc_src_m     <= 1'b0;
            wa3_w        <= '0;
            reg_write_w  <= 1'b0;
            pc_src_w     <= 1'b0;
        end else begin
            wa3_m        <= WA3E;
            reg_write_m  <= RegWriteE;
            mem_to_reg_m <= MemtoRegE;
            pc_src_m     <= PCSrcE;
            wa3_w        <= wa3_m;
            reg_write_w  <= reg_write_m;
            pc_src_w     <= pc_src_m;
        end
    end

    // Forward select for one Execute source; the PC operand is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [RBITS-1:0] ra,
        input logic [RBITS-1:0] wa_m,
        input logic             rw_m,
        input logic [RBITS-1:0] wa_w,
        input logic             rw_w
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (ra != PC_REG) begin
            if (rw_m && (ra == wa_m)) begin
                sel = FWD_MEM;
            end else if (rw_w && (ra == wa_w)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // Hazard detection and output equations; reset forces a flushed, unstalled pipe.
    always_comb begin
        ldr_stall  = 1'b0;
        pc_wr_pend = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        ForwardAE  = FWD_RF;
        ForwardBE  = FWD_RF;

        ldr_stall  = MemtoRegE && RegWriteE && (WA3E != PC_REG) &&
                     ((RA1D == WA3E) || (RA2D == WA3E));
        pc_wr_pend = PCSrcD || PCSrcE || pc_src_m;

        if (!RST_N) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else begin
            StallF    = ldr_stall || pc_wr_pend;
            StallD    = ldr_stall;
            FlushD    = pc_wr_pend || pc_src_w || BranchTakenE;
            FlushE    = ldr_stall || BranchTakenE;
            ForwardAE = fwd_sel(RA1E, wa3_m, reg_write_m, wa3_w, reg_write_w);
            ForwardBE = fwd_sel(RA2E, wa3_m, reg_write_m, wa3_w, reg_write_w);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Event counters, wrapping naturally at 2^32.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            LdStallCnt <= '0;
            FlushCnt   <= '0;
        end else begin
            if (ldr_stall) begin
                LdStallCnt <= LdStallCnt + 32'd1;
            end
            if (BranchTakenE || pc_src_w) begin
                FlushCnt <= FlushCnt + 32'd1;
            end
        end
    end
`else
    // mem_to_reg_m is kept for shadow completeness; fold it into a harmless sink.
    logic unused_ok;
    assign unused_ok = mem_to_reg_m;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic       CLK;
    logic       RST_N;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E;
    logic       RegWriteE, MemtoRegE, PCSrcD, PCSrcE, BranchTakenE;
    logic       StallF, StallD, FlushD, FlushE;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] LdStallCnt, FlushCnt;
`endif

    hazard_unit #(.RBITS(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
`ifdef HAZARD_PERF_CNT_EN
        , .LdStallCnt(LdStallCnt), .FlushCnt(FlushCnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: the instructions that have left Execute, newest first
    // (index 0 is in Memory, index 1 in Writeback).
    typedef struct {
        logic [3:0] wa;
        logic       rw;
        logic       pcs;
    } instr_t;

    instr_t older[$];
    int unsigned m_ldcnt;
    int unsigned m_flcnt;
    int n_assert;
    int n_fail;

    function automatic instr_t bubble();
        instr_t b;
        b.wa = 4'd0; b.rw = 1'b0; b.pcs = 1'b0;
        return b;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [3:0] ra);
        if (ra == 4'd15) return 2'b00;
        for (int i = 0; i < 2; i++)
            if (older[i].rw && older[i].wa == ra) return (i == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic logic exp_ldr();
        return MemtoRegE && RegWriteE && WA3E != 4'd15 && (RA1D == WA3E || RA2D == WA3E);
    endfunction

    function automatic logic exp_pcpend();
        return PCSrcD || PCSrcE || older[0].pcs;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the present inputs.
    task automatic check_model();
        logic ldr, pcp, bt;
        ldr = exp_ldr();
        pcp = exp_pcpend();
        bt  = BranchTakenE;
        if (!RST_N) begin
            chk("rst_stallf", 32'(StallF), 32'd0);
            chk("rst_stalld", 32'(StallD), 32'd0);
            chk("rst_flushd", 32'(FlushD), 32'd1);
            chk("rst_flushe", 32'(FlushE), 32'd1);
            chk("rst_fwda",   32'(ForwardAE), 32'd0);
            chk("rst_fwdb",   32'(ForwardBE), 32'd0);
        end else begin
            chk("stallf", 32'(StallF), 32'(ldr | pcp));
            chk("stalld", 32'(StallD), 32'(ldr));
            chk("flushd", 32'(FlushD), 32'(pcp | older[1].pcs | bt));
            chk("flushe", 32'(FlushE), 32'(ldr | bt));
            chk("fwda",   32'(ForwardAE), 32'(exp_fwd(RA1E)));
            chk("fwdb",   32'(ForwardBE), 32'(exp_fwd(RA2E)));
        end
`ifdef HAZARD_PERF_CNT_EN
        chk("ldcnt", LdStallCnt, m_ldcnt);
        chk("flcnt", FlushCnt, m_flcnt);
`endif
    endtask

    // Advance one clock; the model retires the current E instruction at the edge.
    task automatic clk_step();
        instr_t e;
        @(posedge CLK);
        if (!RST_N) begin
            older = '{bubble(), bubble()};
            m_ldcnt = 0;
            m_flcnt = 0;
        end else begin
            if (exp_ldr()) m_ldcnt++;
            if (BranchTakenE || older[1].pcs) m_flcnt++;
            e.wa = WA3E; e.rw = RegWriteE; e.pcs = PCSrcE;
            older.push_front(e);
            void'(older.pop_back());
        end
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        RA1D = 0; RA2D = 0; RA1E = 0; RA2E = 0; WA3E = 0;
        RegWriteE = 0; MemtoRegE = 0; PCSrcD = 0; PCSrcE = 0; BranchTakenE = 0;
    endtask

    task automatic rand_inputs();
        RA1D = rreg(); RA2D = rreg(); RA1E = rreg(); RA2E = rreg(); WA3E = rreg();
        RegWriteE = 1'($urandom_range(0, 1));
        MemtoRegE = 1'($urandom_range(0, 2) == 0);
        PCSrcD = 1'($urandom_range(0, 7) == 0);
        PCSrcE = 1'($urandom_range(0, 7) == 0);
        BranchTakenE = 1'($urandom_range(0, 7) == 0);
    endtask

    // Small register range so matches happen often; r15 appears occasionally.
    function automatic logic [3:0] rreg();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    // Drive is done by the caller after a negedge; check #1 later, then clock.
    task automatic settle_check();
        #1;
        check_model();
    endtask

    logic [4:0] pc_stall_exp;
    logic [4:0] pc_flush_exp;

    initial begin
        n_assert = 0;
        n_fail = 0;
        m_ldcnt = 0;
        m_flcnt = 0;
        older = '{bubble(), bubble()};

        // Reset for two cycles with arbitrary inputs.
        RST_N = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_inputs();
            settle_check();
            chk("rst_flushd_c", 32'(FlushD), 32'd1);
            clk_step();
        end

        // Release with idle inputs: everything quiet.
        RST_N = 1'b1;
        idle_inputs();
        settle_check();
        chk("rel_stallf", 32'(StallF), 32'd0);
        chk("rel_flushd", 32'(FlushD), 32'd0);
        chk("rel_fwda",   32'(ForwardAE), 32'd0);
        clk_step();

        // ALU forwarding: M then W.
        WA3E = 4'd3; RegWriteE = 1'b1;
        settle_check();
        clk_step();
        idle_inputs(); RA1E = 4'd3;
        settle_check();
        chk("alu_fwd_m", 32'(ForwardAE), 32'd2);
        clk_step();
        idle_inputs(); RA2E = 4'd3;
        settle_check();
        chk("alu_fwd_w", 32'(ForwardBE), 32'd1);
        clk_step();

        // Priority M over W, and r15 never forwards.
        idle_inputs(); WA3E = 4'd5; RegWriteE = 1'b1;
        settle_check(); clk_step();
        settle_check(); clk_step();
        idle_inputs(); RA1E = 4'd5;
        settle_check();
        chk("prio_m", 32'(ForwardAE), 32'd2);
        clk_step();
        idle_inputs(); WA3E = 4'd15; RegWriteE = 1'b1;
        settle_check(); clk_step();
        settle_check(); clk_step();
        idle_inputs(); RA1E = 4'd15;
        settle_check();
        chk("r15_nofwd", 32'(ForwardAE), 32'd0);
        clk_step();

        // Load-use: one stall cycle, bubble, then WB forward.
        idle_inputs(); settle_check(); clk_step();
        idle_inputs(); MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd2; RA2D = 4'd2;
        settle_check();
        chk("ldu_stallf", 32'(StallF), 32'd1);
        chk("ldu_stalld", 32'(StallD), 32'd1);
        chk("ldu_flushe", 32'(FlushE), 32'd1);
        chk("ldu_flushd", 32'(FlushD), 32'd0);
        clk_step();
        idle_inputs();
        settle_check();
        chk("ldu_bub_stallf", 32'(StallF), 32'd0);
        chk("ldu_bub_flushe", 32'(FlushE), 32'd0);
        clk_step();
        idle_inputs(); RA2E = 4'd2;
        settle_check();
        chk("ldu_fwd_w", 32'(ForwardBE), 32'd1);
        clk_step();

        // PC write in Decode: 3 cycles of fetch stall, 4 of Decode flush.
        idle_inputs(); settle_check(); clk_step();
        settle_check(); clk_step();
        pc_stall_exp = 5'b00111;
        pc_flush_exp = 5'b01111;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c == 0) PCSrcD = 1'b1;
            if (c == 1) PCSrcE = 1'b1;
            settle_check();
            chk($sformatf("pcw_stallf_%0d", c), 32'(StallF), 32'(pc_stall_exp[c]));
            chk($sformatf("pcw_flushd_%0d", c), 32'(FlushD), 32'(pc_flush_exp[c]));
            clk_step();
        end

        // Taken branch: flush D and E for one cycle only.
        idle_inputs(); BranchTakenE = 1'b1;
        settle_check();
        chk("br_flushd", 32'(FlushD), 32'd1);
        chk("br_flushe", 32'(FlushE), 32'd1);
        chk("br_stallf", 32'(StallF), 32'd0);
        clk_step();
        idle_inputs();
        settle_check();
        chk("br_after_flushd", 32'(FlushD), 32'd0);
        chk("br_after_flushe", 32'(FlushE), 32'd0);
        clk_step();

        // Branch together with load-use.
        idle_inputs(); BranchTakenE = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1;
        WA3E = 4'd1; RA1D = 4'd1;
        settle_check();
        chk("brldu_stalld", 32'(StallD), 32'd1);
        chk("brldu_flushd", 32'(FlushD), 32'd1);
        clk_step();

        // Random traffic with occasional resets (including mid-stall).
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            RST_N = 1'($urandom_range(0, 31) != 0);
            settle_check();
            clk_step();
        end

        RST_N = 1'b1;
        idle_inputs();
        settle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
